// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_unit: FETCH/DECODE/EXEC/WB sequencer for the          |
// | multi-cycle datapath. Optional macro: CU_ILLEGAL_TRAP_EN (trap on bad op)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                Jump,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_JUMP   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [OPCODE_W-1:0] c_OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] c_OP_MOVI  = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] c_OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] c_OP_SUBI  = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] c_OP_J     = OPCODE_W'(6'b000010);
  localparam logic [ALUOP_W-1:0]  c_ALUOP_R  = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0]  c_ALUOP_I  = ALUOP_W'(2'b00);

  state_t              r_state;
  logic [OPCODE_W-1:0] r_op;
  logic                r_imem_req;
  logic                r_pcwrite;
  logic                r_regdst;
  logic                r_alusrc;
  logic                r_regwrite;
  logic                r_jump;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_next_state;
  logic [OPCODE_W-1:0] w_next_op;
  logic                w_is_rtype;
  logic                w_is_imm;
  logic                w_in_alu;

  // Outputs are registered from the next state, so they line up with the
  // state register exactly as a Moore decode of (state, op_q) would.
  always_comb begin
    w_next_op    = (r_state == S_DECODE) ? opcode : r_op;
    w_is_rtype   = (w_next_op == c_OP_RTYPE);
    w_is_imm     = (w_next_op == c_OP_MOVI) || (w_next_op == c_OP_ADDI) ||
                   (w_next_op == c_OP_SUBI);
    w_next_state = r_state;
    case (r_state)
      S_RST:    w_next_state = S_FETCH;
      S_FETCH:  if (imem_ack) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_is_rtype || w_is_imm)
          w_next_state = S_EXEC;
        else if (w_next_op == c_OP_J)
          w_next_state = S_JUMP;
        else
`ifdef CU_ILLEGAL_TRAP_EN
          w_next_state = S_TRAP;
`else
          w_next_state = S_WB;
`endif
      end
      S_EXEC:   w_next_state = S_WB;
      S_WB:     w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      S_TRAP:   w_next_state = S_TRAP;
      default:  w_next_state = S_RST;
    endcase
    w_in_alu = (w_next_state == S_EXEC) || (w_next_state == S_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RST;
      r_op       <= '0;
      r_imem_req <= 1'b0;
      r_pcwrite  <= 1'b0;
      r_regdst   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_jump     <= 1'b0;
      r_aluop    <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_op       <= w_next_op;
      r_imem_req <= (w_next_state == S_FETCH);
      r_pcwrite  <= (w_next_state == S_WB) || (w_next_state == S_JUMP);
      r_regwrite <= (w_next_state == S_WB) && (w_is_rtype || w_is_imm);
      r_jump     <= (w_next_state == S_JUMP);
      r_regdst   <= w_in_alu && w_is_rtype;
      r_alusrc   <= w_in_alu && w_is_imm;
      r_aluop    <= (w_in_alu && w_is_rtype) ? c_ALUOP_R : c_ALUOP_I;
      r_cnt      <= r_cnt + CNT_W'(r_pcwrite);
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_illegal <= 1'b0;
    else
      r_illegal <= r_illegal || (w_next_state == S_TRAP);
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign IRWrite     = (r_state == S_FETCH) && imem_ack;
  assign imem_req    = r_imem_req;
  assign PCWrite     = r_pcwrite;
  assign RegDst      = r_regdst;
  assign ALUSrc      = r_alusrc;
  assign RegWrite    = r_regwrite;
  assign Jump        = r_jump;
  assign ALUOp       = r_aluop;
  assign state       = r_state;
  assign instr_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequential, parametrised control unit for the multi-cycle datapath. It fetches through a request/acknowledge handshake and decodes R-type, MOVI, ADDI, SUBI and J. It sequences the datapath through fetch, decode, execute and write-back, strobing register-file, IR and PC writes in the correct cycle. It sits between instruction memory/IR and the datapath, and keeps a retired-instruction counter for bring-up and debug.

## Interface
Parameters:
- OPCODE_W, 6, opcode width; must be ≥6; bits above [5:0] must be zero for a match
- ALUOP_W, 2, ALUOp width; must be ≥2; codes zero-extended
- CNT_W, 16, retired-instruction counter width

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- opcode  in  OPCODE_W  opcode from IR; sampled only in DECODE
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; ignored outside FETCH
- IRWrite  out  1  load IR; high when in FETCH and imem_ack=1 (combinational)
- PCWrite  out  1  PC update strobe
- RegDst  out  1  1 = rd destination, 0 = rt
- ALUSrc  out  1  1 = immediate operand
- RegWrite  out  1  register-file write strobe
- Jump  out  1  select jump target for PC
- ALUOp  out  ALUOP_W  ALU operation class
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  current FSM state
- instr_count  out  CNT_W  retired instructions

## Operation
- States and encodings: RST=0, FETCH=1, DECODE=2, EXEC=3, WB=4, JUMP=5, TRAP=6.
- Output type: all outputs except IRWrite are Moore, derived from the state register and the latched opcode op_q.
- RST:
  - all outputs 0
  - unconditionally goes to FETCH next cycle
- FETCH:
  - imem_req=1
  - holds until imem_ack=1, then goes to DECODE
- DECODE:
  - op_q ← opcode
  - 000000, 001010, 001000, 001001 → EXEC
  - 000010 → JUMP
  - any other opcode → WB as a NOP (see Configuration for the alternative)
- EXEC and WB outputs by op_q:
  - R-type: RegDst=1, ALUSrc=0, ALUOp=2'b10
  - MOVI/ADDI/SUBI: RegDst=0, ALUSrc=1, ALUOp=2'b00
  - All fields are held stable through both EXEC and WB; they are 0 in every other state.
- EXEC:
  - no strobes
  - → WB
- WB:
  - PCWrite=1
  - RegWrite=1 only if op_q is legal
  - → FETCH
- JUMP:
  - Jump=1, PCWrite=1, RegWrite=0
  - → FETCH
- instr_count:
  - increments by 1 on every cycle with PCWrite=1
  - wraps modulo 2^CNT_W
- Opcode changes after DECODE have no effect.

## Timing
- Reset: asynchronous assert forces state=RST, op_q=0, instr_count=0, illegal=0, and all outputs 0 immediately, including mid-fetch or mid-WB. A write-back interrupted by reset is not performed.
- After reset release: exactly one RST cycle, then FETCH.
- Latency with zero-wait memory (imem_ack high on the first FETCH cycle):
  - R/I instructions: 4 cycles (FETCH, DECODE, EXEC, WB)
  - J: 3 cycles
  - Illegal NOP: 3 cycles
- Each extra FETCH cycle spent waiting for imem_ack adds one cycle.
- Handshake:
  - imem_req stays high until the ack cycle.
  - imem_ack that is already high on FETCH entry completes the fetch in that cycle.
  - imem_req drops the cycle after the ack.
- Strobe widths: RegWrite, PCWrite and Jump are each exactly one cycle wide per instruction.

## Configuration
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE goes to TRAP.
  - TRAP: illegal=1, all strobes and imem_req 0, no further fetches, instr_count frozen.
  - Only rst exits TRAP.
- Undefined:
  - Illegal opcodes execute as a NOP (PCWrite=1, RegWrite=0, counted as retired).
  - TRAP is unreachable; illegal is tied 0.

## Test plan
- Reset release, imem_ack tied 1, opcode=000000 → state 0,1,2,3,4,1; RegWrite=1 only in cycle 5 with RegDst=1, ALUOp=2'b10; instr_count=1.
- ADDI (001000) with imem_ack delayed 3 cycles → imem_req high 4 cycles; WB shows ALUSrc=1, RegDst=0, ALUOp=0, RegWrite=1; total 7 cycles.
- J (000010) → JUMP cycle has Jump=1, PCWrite=1, RegWrite=0; back in FETCH on cycle 4.
- Opcode 111111: with CU_ILLEGAL_TRAP_EN → state=6, illegal=1, imem_req stays 0 for 20 cycles; without it → WB with RegWrite=0, PCWrite=1, instr_count increments.
- rst pulsed during WB of SUBI → RegWrite drops the same cycle, instr_count=0, one RST cycle follows release.
- CNT_W=4: run 17 MOVI instructions → instr_count=1 after wrap.
